// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch flush, memory wait, drain/halt.
// Optional performance counters are enabled by defining PIPE_CTRL_PERF_EN.
module pipeline_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_W        = 32
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [4:0] i_id_rs1_addr,
  input  logic [4:0] i_id_rs2_addr,
  input  logic       i_id_rs1_used,
  input  logic       i_id_rs2_used,
  input  logic [4:0] i_ex_dest_addr,
  input  logic       i_ex_mem_read,
  input  logic       i_ex_branch_taken,
  input  logic       i_ex_pc_write_trap,
  input  logic       i_imem_ready,
  input  logic       i_dmem_req,
  input  logic       i_dmem_ready,
  input  logic       i_halt,
  output logic       o_pc_en,
  output logic       o_if_id_en,
  output logic       o_id_ex_en,
  output logic       o_ex_mem_en,
  output logic       o_mem_wb_en,
  output logic       o_if_id_flush,
  output logic       o_id_ex_flush,
  output logic       o_mem_wb_flush,
  output logic       o_trap,
  output logic       o_halted
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] o_stall_cycles,
  output logic [CNT_W-1:0] o_flush_count
`endif
);

  localparam int unsigned CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {RUN, DMEM_WAIT, DRAIN, HALTED} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          trap_q, trap_d;
  logic          load_use, mem_wait, branch_flush;

  assign load_use = i_ex_mem_read && (i_ex_dest_addr != 5'd0) &&
                    ((i_id_rs1_used && (i_id_rs1_addr == i_ex_dest_addr)) ||
                     (i_id_rs2_used && (i_id_rs2_addr == i_ex_dest_addr)));

  // Once waiting, only dmem_ready releases the freeze; elsewhere a fresh unserved request triggers it.
  assign mem_wait = (state_q == DMEM_WAIT) ? !i_dmem_ready : (i_dmem_req && !i_dmem_ready);

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    trap_d         = trap_q;
    branch_flush   = 1'b0;
    o_pc_en        = 1'b0;
    o_if_id_en     = 1'b0;
    o_id_ex_en     = 1'b0;
    o_ex_mem_en    = 1'b0;
    o_mem_wb_en    = 1'b0;
    o_if_id_flush  = 1'b0;
    o_id_ex_flush  = 1'b0;
    o_mem_wb_flush = 1'b0;
    unique case (state_q)
      RUN, DMEM_WAIT: begin
        if (mem_wait) begin
          o_mem_wb_flush = 1'b1;
          state_d        = DMEM_WAIT;
        end else begin
          state_d = RUN;
          if (i_halt || i_ex_pc_write_trap) begin
            o_ex_mem_en   = 1'b1;
            o_mem_wb_en   = 1'b1;
            o_if_id_flush = 1'b1;
            o_id_ex_flush = 1'b1;
            trap_d        = i_ex_pc_write_trap;
            cnt_d         = CW'(DRAIN_CYCLES - 1);
            state_d       = DRAIN;
          end else if (i_ex_branch_taken) begin
            {o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_en} = '1;
            o_if_id_flush = 1'b1;
            o_id_ex_flush = 1'b1;
            branch_flush  = 1'b1;
          end else if (load_use) begin
            o_id_ex_en    = 1'b1;
            o_ex_mem_en   = 1'b1;
            o_mem_wb_en   = 1'b1;
            o_id_ex_flush = 1'b1;
          end else if (!i_imem_ready) begin
            {o_if_id_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_en} = '1;
            o_if_id_flush = 1'b1;
          end else begin
            {o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_en} = '1;
          end
        end
      end
      DRAIN: begin
        if (mem_wait) begin
          o_mem_wb_flush = 1'b1;
        end else begin
          o_ex_mem_en   = 1'b1;
          o_mem_wb_en   = 1'b1;
          o_id_ex_flush = 1'b1;
          if (cnt_q == '0) state_d = HALTED;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      default: ;  // HALTED: frozen until reset
    endcase
    // Held in reset: whole pipe frozen and filled with bubbles.
    if (!i_rst) begin
      {o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_en} = '0;
      {o_if_id_flush, o_id_ex_flush, o_mem_wb_flush}              = '1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      trap_q  <= trap_d;
    end
  end

  assign o_trap   = trap_q;
  assign o_halted = (state_q == HALTED);

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             in_run;

  assign in_run = (state_q == RUN) || (state_q == DMEM_WAIT);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (in_run && !o_pc_en) stall_q <= stall_q + 1'b1;
      if (branch_flush)       flush_q <= flush_q + 1'b1;
    end
  end

  assign o_stall_cycles = stall_q;
  assign o_flush_count  = flush_q;
`else
  logic unused_perf;
  assign unused_perf = (CNT_W == 0) ^ branch_flush;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed testbench for pipeline_ctrl (DRAIN_CYCLES=3); perf checks run when PIPE_CTRL_PERF_EN is defined.
module tb_pipeline_ctrl;
  logic       i_clk = 1'b0;
  logic       i_rst;
  logic [4:0] i_id_rs1_addr, i_id_rs2_addr, i_ex_dest_addr;
  logic       i_id_rs1_used, i_id_rs2_used, i_ex_mem_read, i_ex_branch_taken;
  logic       i_ex_pc_write_trap, i_imem_ready, i_dmem_req, i_dmem_ready, i_halt;
  logic       o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_en;
  logic       o_if_id_flush, o_id_ex_flush, o_mem_wb_flush, o_trap, o_halted;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] o_stall_cycles, o_flush_count;
`endif
  logic [7:0] outs;
  int         n_checks = 0;
  int         n_fail   = 0;

  // {pc, if_id, id_ex, ex_mem, mem_wb enables, if_id, id_ex, mem_wb flushes}
  assign outs = {o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_en,
                 o_if_id_flush, o_id_ex_flush, o_mem_wb_flush};

  always #5 i_clk = ~i_clk;

  pipeline_ctrl #(.DRAIN_CYCLES(3), .CNT_W(32)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_id_rs1_addr(i_id_rs1_addr), .i_id_rs2_addr(i_id_rs2_addr),
    .i_id_rs1_used(i_id_rs1_used), .i_id_rs2_used(i_id_rs2_used),
    .i_ex_dest_addr(i_ex_dest_addr), .i_ex_mem_read(i_ex_mem_read),
    .i_ex_branch_taken(i_ex_branch_taken), .i_ex_pc_write_trap(i_ex_pc_write_trap),
    .i_imem_ready(i_imem_ready), .i_dmem_req(i_dmem_req), .i_dmem_ready(i_dmem_ready),
    .i_halt(i_halt),
    .o_pc_en(o_pc_en), .o_if_id_en(o_if_id_en), .o_id_ex_en(o_id_ex_en),
    .o_ex_mem_en(o_ex_mem_en), .o_mem_wb_en(o_mem_wb_en),
    .o_if_id_flush(o_if_id_flush), .o_id_ex_flush(o_id_ex_flush),
    .o_mem_wb_flush(o_mem_wb_flush), .o_trap(o_trap), .o_halted(o_halted)
`ifdef PIPE_CTRL_PERF_EN
    , .o_stall_cycles(o_stall_cycles), .o_flush_count(o_flush_count)
`endif
  );

  task automatic idle_inputs();
    i_id_rs1_addr = 5'd0; i_id_rs2_addr = 5'd0; i_ex_dest_addr = 5'd0;
    i_id_rs1_used = 1'b0; i_id_rs2_used = 1'b0; i_ex_mem_read = 1'b0;
    i_ex_branch_taken = 1'b0; i_ex_pc_write_trap = 1'b0; i_imem_ready = 1'b1;
    i_dmem_req = 1'b0; i_dmem_ready = 1'b0; i_halt = 1'b0;
  endtask

  // Move to the falling edge, where inputs change and outputs are sampled #1 later.
  task automatic step();
    @(negedge i_clk);
    idle_inputs();
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    idle_inputs();
    i_rst = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    i_rst = 1'b0;
    #1;
    n_checks++;
    if (outs !== 8'b00000_111) begin n_fail++; $display("FAIL reset_held outs=%b exp=%b", outs, 8'b00000_111); end
    n_checks++;
    if ({o_trap, o_halted} !== 2'b00) begin n_fail++; $display("FAIL reset_sticky trap/halted=%b exp=00", {o_trap, o_halted}); end
    @(negedge i_clk); @(negedge i_clk);
    i_rst = 1'b1;
    step(); #1;
    n_checks++;
    if (outs !== 8'b11111_000) begin n_fail++; $display("FAIL reset_release outs=%b exp=%b", outs, 8'b11111_000); end
  endtask

  task automatic test_load_use();
    // lw x5 in EX, ID is add x6,x5,x1
    step();
    i_ex_mem_read = 1'b1; i_ex_dest_addr = 5'd5;
    i_id_rs1_used = 1'b1; i_id_rs1_addr = 5'd5; i_id_rs2_used = 1'b1; i_id_rs2_addr = 5'd1;
    #1;
    n_checks++;
    if (outs !== 8'b00111_010) begin n_fail++; $display("FAIL load_use_rs1 outs=%b exp=%b", outs, 8'b00111_010); end
    step(); #1;
    n_checks++;
    if (outs !== 8'b11111_000) begin n_fail++; $display("FAIL load_use_after outs=%b exp=%b", outs, 8'b11111_000); end
    // rs2 dependency
    step();
    i_ex_mem_read = 1'b1; i_ex_dest_addr = 5'd7;
    i_id_rs1_used = 1'b1; i_id_rs1_addr = 5'd3; i_id_rs2_used = 1'b1; i_id_rs2_addr = 5'd7;
    #1;
    n_checks++;
    if (outs !== 8'b00111_010) begin n_fail++; $display("FAIL load_use_rs2 outs=%b exp=%b", outs, 8'b00111_010); end
    // matching address but rs2 not used -> no stall
    step();
    i_ex_mem_read = 1'b1; i_ex_dest_addr = 5'd7; i_id_rs2_used = 1'b0; i_id_rs2_addr = 5'd7;
    #1;
    n_checks++;
    if (outs !== 8'b11111_000) begin n_fail++; $display("FAIL load_use_unused outs=%b exp=%b", outs, 8'b11111_000); end
    // load to x0, ID reads x0 -> no stall
    step();
    i_ex_mem_read = 1'b1; i_ex_dest_addr = 5'd0; i_id_rs1_used = 1'b1; i_id_rs1_addr = 5'd0;
    #1;
    n_checks++;
    if (outs !== 8'b11111_000) begin n_fail++; $display("FAIL load_x0 outs=%b exp=%b", outs, 8'b11111_000); end
  endtask

  task automatic test_branch();
    step();
    i_ex_branch_taken = 1'b1;
    i_ex_mem_read = 1'b1; i_ex_dest_addr = 5'd5; i_id_rs1_used = 1'b1; i_id_rs1_addr = 5'd5;
    #1;
    n_checks++;
    if (outs !== 8'b11111_110) begin n_fail++; $display("FAIL branch_over_load_use outs=%b exp=%b", outs, 8'b11111_110); end
    step();
    i_ex_branch_taken = 1'b1; i_imem_ready = 1'b0;
    #1;
    n_checks++;
    if (outs !== 8'b11111_110) begin n_fail++; $display("FAIL branch_over_imem outs=%b exp=%b", outs, 8'b11111_110); end
  endtask

  task automatic test_imem_wait();
    step();
    i_imem_ready = 1'b0;
    #1;
    n_checks++;
    if (outs !== 8'b01111_100) begin n_fail++; $display("FAIL imem_wait outs=%b exp=%b", outs, 8'b01111_100); end
  endtask

  task automatic test_dmem_wait();
    for (int c = 0; c < 3; c++) begin
      step();
      i_dmem_req = 1'b1; i_dmem_ready = 1'b0;
      if (c > 0) i_ex_branch_taken = 1'b1;  // must be ignored while frozen
      #1;
      n_checks++;
      if (outs !== 8'b00000_001) begin n_fail++; $display("FAIL dmem_wait_c%0d outs=%b exp=%b", c, outs, 8'b00000_001); end
    end
    step();
    i_dmem_req = 1'b1; i_dmem_ready = 1'b1;
    #1;
    n_checks++;
    if (outs !== 8'b11111_000) begin n_fail++; $display("FAIL dmem_ready outs=%b exp=%b", outs, 8'b11111_000); end
    step(); #1;
    n_checks++;
    if (outs !== 8'b11111_000) begin n_fail++; $display("FAIL dmem_back_run outs=%b exp=%b", outs, 8'b11111_000); end
    // a wait released together with a load-use applies the load-use stall
    step();
    i_dmem_req = 1'b1;
    step();
    i_dmem_ready = 1'b1;
    i_ex_mem_read = 1'b1; i_ex_dest_addr = 5'd9; i_id_rs2_used = 1'b1; i_id_rs2_addr = 5'd9;
    #1;
    n_checks++;
    if (outs !== 8'b00111_010) begin n_fail++; $display("FAIL dmem_ready_load_use outs=%b exp=%b", outs, 8'b00111_010); end
  endtask

  task automatic test_trap();
    step();
    i_ex_pc_write_trap = 1'b1;
    #1;
    n_checks++;
    if (outs !== 8'b00011_110) begin n_fail++; $display("FAIL trap_entry outs=%b exp=%b", outs, 8'b00011_110); end
    // three drain cycles, with one memory wait inserted that must not consume one
    for (int c = 0; c < 4; c++) begin
      step();
      if (c == 1) begin
        i_dmem_req = 1'b1;
        #1;
        n_checks++;
        if (outs !== 8'b00000_001) begin n_fail++; $display("FAIL drain_dmem outs=%b exp=%b", outs, 8'b00000_001); end
      end else begin
        #1;
        n_checks++;
        if ({outs, o_trap, o_halted} !== 10'b00011_010_10) begin
          n_fail++; $display("FAIL drain_c%0d outs/trap/halted=%b exp=%b", c, {outs, o_trap, o_halted}, 10'b00011_010_10);
        end
      end
    end
    step();
    i_ex_branch_taken = 1'b1; i_halt = 1'b1;
    #1;
    n_checks++;
    if ({outs, o_trap, o_halted} !== 10'b00000_000_11) begin
      n_fail++; $display("FAIL halted outs/trap/halted=%b exp=%b", {outs, o_trap, o_halted}, 10'b00000_000_11);
    end
    step(); #1;
    n_checks++;
    if (o_halted !== 1'b1) begin n_fail++; $display("FAIL halted_sticky halted=%b exp=1", o_halted); end
    #2 i_rst = 1'b0;
    #1;
    n_checks++;
    if ({outs, o_trap, o_halted} !== 10'b00000_111_00) begin
      n_fail++; $display("FAIL trap_reset outs/trap/halted=%b exp=%b", {outs, o_trap, o_halted}, 10'b00000_111_00);
    end
    @(negedge i_clk);
    i_rst = 1'b1;
  endtask

  task automatic test_halt_reset_mid_drain();
    step();
    i_halt = 1'b1;
    #1;
    n_checks++;
    if (outs !== 8'b00011_110) begin n_fail++; $display("FAIL halt_entry outs=%b exp=%b", outs, 8'b00011_110); end
    step(); #1;
    n_checks++;
    if ({outs, o_trap} !== 9'b00011_010_0) begin n_fail++; $display("FAIL halt_no_trap outs/trap=%b exp=%b", {outs, o_trap}, 9'b00011_010_0); end
    #2 i_rst = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b1;
    step(); #1;
    n_checks++;
    if ({outs, o_trap, o_halted} !== 10'b11111_000_00) begin
      n_fail++; $display("FAIL reset_mid_drain outs/trap/halted=%b exp=%b", {outs, o_trap, o_halted}, 10'b11111_000_00);
    end
  endtask

`ifdef PIPE_CTRL_PERF_EN
  task automatic test_perf();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      step();
      i_ex_mem_read = 1'b1; i_ex_dest_addr = 5'd5; i_id_rs1_used = 1'b1; i_id_rs1_addr = 5'd5;
      step();
    end
    for (int k = 0; k < 2; k++) begin
      step();
      i_ex_branch_taken = 1'b1;
    end
    step(); #1;
    n_checks++;
    if (o_stall_cycles !== 32'd5) begin n_fail++; $display("FAIL perf_stalls got=%0d exp=5", o_stall_cycles); end
    n_checks++;
    if (o_flush_count !== 32'd2) begin n_fail++; $display("FAIL perf_flushes got=%0d exp=2", o_flush_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_imem_wait();
    test_dmem_wait();
    test_trap();
    test_halt_reset_mid_drain();
`ifdef PIPE_CTRL_PERF_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
